systolic_array_seq: RTL



---
 rtl/systolic_pkg.sv | 40 ++++
 rtl/seq_tag_pipe.sv | 36 +++
 rtl/systolic_array_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic chain sequencer: ctrl word layout, op codes
// and sequencer FSM states.
package systolic_pkg;

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_LOAD_W  = 2'd1,
    OP_COMPUTE = 2'd2,
    OP_FLUSH   = 2'd3
  } ctrl_op_e;

  // Ctrl word: [8]=vld, [7:6]=op, [5:0]=index (weight row / iact idx mod 64)
  typedef struct packed {
    logic               vld;
    ctrl_op_e           op;
    logic [IDX_W-1:0]   idx;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '{vld: 1'b0, op: OP_NOP, idx: '0};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  // Build a valid ctrl word for the given op and index.
  function automatic ctrl_word_t mk_ctrl(input ctrl_op_e op, input logic [IDX_W-1:0] idx);
    ctrl_word_t w;
    w.vld = 1'b1;
    w.op  = op;
    w.idx = idx;
    return w;
  endfunction

endpackage

// File: rtl/seq_tag_pipe.sv
// Delay line for "COMPUTE issued" tags. A tag entering on bit_i appears on
// tail_o LEN cycles later; feed_o is the bit that will be in the tail after
// the next edge, so the parent can capture data on that same edge.
module seq_tag_pipe #(
  parameter int unsigned LEN = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_i,
  output logic tail_o,
  output logic feed_o
);

  logic [LEN-1:0] pipe_q;
  logic [LEN-1:0] pipe_d;
  logic [LEN:0]   ext;

  // Shift the new tag in at the bottom; works for LEN=1 as well.
  always_comb begin
    ext    = {pipe_q, bit_i};
    pipe_d = ext[LEN-1:0];
  end

  assign feed_o = ext[LEN-1];
  assign tail_o = pipe_q[LEN-1];

  // Delay line register, cleared by reset so no stale tags survive a job abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/systolic_array_seq.sv
// Sequencer for one chain of systolic routers. Loads weights, streams input
// activations and drains the chain, driving router 0's ctrl/iact bus from
// registers. A delayed issue tag marks when each psum leaves the chain tail.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in LOAD and COMPUTE and does not depend on in_valid;
// res_valid has no backpressure.
module systolic_array_seq
  import systolic_pkg::*;
#(
  parameter int unsigned I_WIDTH    = 8,
  parameter int unsigned P_WIDTH    = 20,
  parameter int unsigned CTRL_WIDTH = 9,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PE_LAT     = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [CNT_W-1:0]      cfg_n_wt,
  input  logic [CNT_W-1:0]      cfg_n_iact,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [I_WIDTH-1:0]    in_data,
  output logic                  in_ready,
  output logic [CTRL_WIDTH-1:0] arr_ctrl,
  output logic [I_WIDTH-1:0]    arr_iact,
  input  logic [P_WIDTH-1:0]    arr_psum,
  output logic                  res_valid,
  output logic [P_WIDTH-1:0]    res_data,
  output state_e                dbg_state_o
);

  localparam int unsigned LAT    = DEPTH + PE_LAT;
  localparam int unsigned DCNT_W = $clog2(LAT + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   n_wt_q;
  logic [CNT_W-1:0]   n_iact_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DCNT_W-1:0]  dcnt_q;
  ctrl_word_t         arr_ctrl_q;
  logic [I_WIDTH-1:0] arr_iact_q;
  logic               done_q;
  logic [P_WIDTH-1:0] res_data_q;

  logic xfer;
  logic last_wt;
  logic last_iact;
  logic issue;
  logic tag_tail;
  logic tag_feed;

  // Handshake and end-of-phase decode.
  always_comb begin
    in_ready  = (state_q == S_LOAD) || (state_q == S_COMPUTE);
    xfer      = in_valid && in_ready;
    last_wt   = (cnt_q == n_wt_q - CNT_W'(1));
    last_iact = (cnt_q == n_iact_q - CNT_W'(1));
    issue     = arr_ctrl_q.vld && (arr_ctrl_q.op == OP_COMPUTE);
  end

  // Job FSM with counters and registered array-edge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_wt_q     <= '0;
      n_iact_q   <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      arr_ctrl_q <= CTRL_NOP;
      arr_iact_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      arr_ctrl_q <= CTRL_NOP;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            n_wt_q   <= cfg_n_wt;
            n_iact_q <= cfg_n_iact;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            if (cfg_n_wt != '0)        state_q <= S_LOAD;
            else if (cfg_n_iact != '0) state_q <= S_COMPUTE;
            else                       state_q <= S_DRAIN;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            arr_ctrl_q <= mk_ctrl(OP_LOAD_W, cnt_q[IDX_W-1:0]);
            arr_iact_q <= in_data;
            if (last_wt) begin
              cnt_q   <= '0;
              state_q <= (n_iact_q != '0) ? S_COMPUTE : S_DRAIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (xfer) begin
            arr_ctrl_q <= mk_ctrl(OP_COMPUTE, cnt_q[IDX_W-1:0]);
            arr_iact_q <= in_data;
            if (last_iact) begin
              cnt_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // First DRAIN edge emits FLUSH; done lands LAT cycles after it.
          if (dcnt_q == '0) begin
            arr_ctrl_q <= mk_ctrl(OP_FLUSH, '0);
          end
          if (dcnt_q == DCNT_W'(LAT)) begin
            dcnt_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  seq_tag_pipe #(
    .LEN (LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_i  (issue),
    .tail_o (tag_tail),
    .feed_o (tag_feed)
  );

  // Capture the tail psum on the edge its tag reaches the end of the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= '0;
    end else if (tag_feed) begin
      res_data_q <= arr_psum;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign arr_ctrl    = arr_ctrl_q;
  assign arr_iact    = arr_iact_q;
  assign res_valid   = tag_tail;
  assign res_data    = res_data_q;
  assign dbg_state_o = state_q;

endmodule
